// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch responder between the PC register and a
// request/acknowledge memory bus. Fetches the word at pc whenever ce is high,
// holds the pipeline via stall_req while the fetch is outstanding, and hands the
// word to IF/ID as inst with a one-cycle inst_valid strobe. A flush kills any
// in-flight word (the bus transaction itself always completes).
//
// Optional feature: define IFETCH_HOLD_BUF_EN to add a single-entry hold buffer
// that replays the last fetched word with 1-cycle latency and no bus traffic
// when the same word address is fetched again.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   pc          in   fetch address
//   ce          in   fetch enable
//   flush       in   taken branch, discard the current fetch
//   stall_req   out  combinational; high while the word for pc is unavailable
//   inst        out  fetched instruction (registered, holds when not valid)
//   inst_valid  out  one-cycle strobe qualifying inst (registered)
//   mem_req     out  bus request (registered)
//   mem_addr    out  bus word address (registered)
//   mem_ack     in   bus acknowledge, mem_rdata valid in the same cycle
//   mem_rdata   in   bus read data
module inst_fetch #(
    parameter logic [31:0] RESET_INST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        ce,
    input  logic        flush,
    output logic        stall_req,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DROP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              mem_req_nxt;
    logic [XLEN-1:0]   mem_addr_nxt;
    logic [XLEN-1:0]   inst_nxt;
    logic              inst_valid_nxt;
    logic              stall_raw;
    logic [XLEN-1:0]   pc_aligned;
    logic              hit;
    logic [XLEN-1:0]   hit_data;
    logic [1:0]        pc_lsb_unused;

    // Word-align the fetch address; the byte offset bits are not needed.
    assign pc_aligned    = {pc[XLEN-1:2], 2'b00};
    assign pc_lsb_unused = pc[1:0];

`ifdef IFETCH_HOLD_BUF_EN
    logic [XLEN-1:0] buf_addr;
    logic [XLEN-1:0] buf_data;
    logic            buf_valid;
    logic            buf_wr;

    // Capture every acknowledge whose data is actually delivered.
    assign buf_wr = (state == REQ) && mem_ack && !flush;

    // Single-entry hold buffer; a flush invalidates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_addr  <= '0;
            buf_data  <= '0;
            buf_valid <= 1'b0;
        end else if (buf_wr) begin
            buf_addr  <= mem_addr;
            buf_data  <= mem_rdata;
            buf_valid <= 1'b1;
        end else if (flush) begin
            buf_valid <= 1'b0;
        end
    end

    // A flush in IDLE also kills a would-be hit, so that fetch goes to the bus.
    assign hit      = (state == IDLE) && ce && !flush && buf_valid
                      && (pc_aligned == buf_addr);
    assign hit_data = buf_data;
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ce && !hit) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end else if (flush) begin
                    state_nxt = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values for the registered outputs plus the stall request.
    always_comb begin
        mem_req_nxt    = mem_req;
        mem_addr_nxt   = mem_addr;
        inst_nxt       = inst;
        inst_valid_nxt = 1'b0;
        stall_raw      = 1'b0;
        case (state)
            IDLE: begin
                if (ce) begin
                    if (hit) begin
                        inst_nxt       = hit_data;
                        inst_valid_nxt = 1'b1;
                    end else begin
                        mem_req_nxt  = 1'b1;
                        mem_addr_nxt = pc_aligned;
                        stall_raw    = 1'b1;
                    end
                end
            end
            REQ: begin
                stall_raw = !mem_ack;
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                    if (!flush) begin
                        inst_nxt       = mem_rdata;
                        inst_valid_nxt = 1'b1;
                    end
                end
            end
            DROP: begin
                // Transaction must complete on the bus, but its data is discarded.
                stall_raw = !mem_ack;
                if (mem_ack) begin
                    mem_req_nxt = 1'b0;
                end
            end
            default: begin
                mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Stall is suppressed during reset so the stall controller sees a clean 0.
    assign stall_req = rst_n && stall_raw;

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req    <= 1'b0;
            mem_addr   <= '0;
            inst       <= RESET_INST;
            inst_valid <= 1'b0;
        end else begin
            mem_req    <= mem_req_nxt;
            mem_addr   <= mem_addr_nxt;
            inst       <= inst_nxt;
            inst_valid <= inst_valid_nxt;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch.
module tb_inst_fetch;

    localparam logic [31:0] RST_INST = 32'hA5A5_0001;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        ce;
    logic        flush;
    logic        stall_req;
    logic [31:0] inst;
    logic        inst_valid;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_cmp;
    int n_err;

    inst_fetch #(.RESET_INST(RST_INST)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pc         (pc),
        .ce         (ce),
        .flush      (flush),
        .stall_req  (stall_req),
        .inst       (inst),
        .inst_valid (inst_valid),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pc = '0; ce = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
        tick(); tick();
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL rst_mem_req got=%0h exp=0", mem_req); end
        n_cmp++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
        n_cmp++; if (inst !== RST_INST) begin n_err++; $display("FAIL rst_inst got=%0h exp=%0h", inst, RST_INST); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_inst_valid got=%0h exp=0", inst_valid); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%0h exp=0", stall_req); end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (mem_req !== 1'b0 || stall_req !== 1'b0) begin
                n_err++; $display("FAIL rst_idle_noreq got=%0h/%0h exp=0/0", mem_req, stall_req);
            end
        end
    endtask

    task automatic test_reset_mid_req();
        pc = 32'h300; ce = 1'b1;
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL midrst_req_before got=%0h exp=1", mem_req); end
        ce = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL midrst_mem_req got=%0h exp=0", mem_req); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid got=%0h exp=0", inst_valid); end
        n_cmp++; if (inst !== RST_INST) begin n_err++; $display("FAIL midrst_inst got=%0h exp=%0h", inst, RST_INST); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL midrst_stall got=%0h exp=0", stall_req); end
        tick();
        rst_n = 1'b1;
        tick();
        mem_ack = 1'b0;
        settle();
        n_cmp++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL midrst_late_ack got=%0h/%0h exp=0/0", inst_valid, mem_req);
        end
        n_cmp++; if (inst !== RST_INST) begin n_err++; $display("FAIL midrst_late_inst got=%0h exp=%0h", inst, RST_INST); end
    endtask

    task automatic test_zero_wait();
        pc = 32'h100; ce = 1'b1; mem_ack = 1'b0;
        settle();
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL zw_stall_n got=%0h exp=1", stall_req); end
        tick();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL zw_mem_req got=%0h exp=1", mem_req); end
        n_cmp++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL zw_mem_addr got=%0h exp=100", mem_addr); end
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL zw_valid_early got=%0h exp=0", inst_valid); end
        mem_ack = 1'b1; mem_rdata = 32'h2402_0005; ce = 1'b0;
        settle();
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL zw_stall_ack got=%0h exp=0", stall_req); end
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid got=%0h exp=1", inst_valid); end
        n_cmp++; if (inst !== 32'h2402_0005) begin n_err++; $display("FAIL zw_inst got=%0h exp=24020005", inst); end
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL zw_req_drop got=%0h exp=0", mem_req); end
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL zw_strobe_len got=%0h exp=0", inst_valid); end
        n_cmp++; if (inst !== 32'h2402_0005) begin n_err++; $display("FAIL zw_inst_hold got=%0h exp=24020005", inst); end
    endtask

    task automatic test_wait_states();
        int stall_cnt;
        int valid_cnt;
        logic exp_s;
        pc = 32'h120; ce = 1'b1; mem_ack = 1'b0;
        settle();
        stall_cnt = int'(stall_req);
        valid_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            ce = 1'b0;
            mem_ack = (i == 3);
            mem_rdata = (i == 3) ? 32'h8C43_0010 : 32'hFFFF_FFFF;
            settle();
            exp_s = (i != 3);
            n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h120) begin
                n_err++; $display("FAIL ws_bus_stable cyc=%0d got=%0h/%0h exp=1/120", i, mem_req, mem_addr);
            end
            n_cmp++; if (stall_req !== exp_s) begin
                n_err++; $display("FAIL ws_stall cyc=%0d got=%0h exp=%0h", i, stall_req, exp_s);
            end
            stall_cnt += int'(stall_req);
            valid_cnt += int'(inst_valid);
        end
        tick();
        mem_ack = 1'b0;
        valid_cnt += int'(inst_valid);
        n_cmp++; if (inst !== 32'h8C43_0010) begin n_err++; $display("FAIL ws_inst got=%0h exp=8c430010", inst); end
        tick();
        valid_cnt += int'(inst_valid);
        n_cmp++; if (stall_cnt != 4) begin n_err++; $display("FAIL ws_stall_cycles got=%0d exp=4", stall_cnt); end
        n_cmp++; if (valid_cnt != 1) begin n_err++; $display("FAIL ws_valid_pulses got=%0d exp=1", valid_cnt); end
    endtask

    task automatic test_flush_mid_fetch();
        logic [31:0] prev;
        prev = inst;
        pc = 32'h140; ce = 1'b1; mem_ack = 1'b0;
        tick();
        flush = 1'b1; ce = 1'b0;
        settle();
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL fl_stall_req got=%0h exp=1", stall_req); end
        tick();
        flush = 1'b0;
        settle();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h140) begin
            n_err++; $display("FAIL fl_drop_hold got=%0h/%0h exp=1/140", mem_req, mem_addr);
        end
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL fl_drop_stall got=%0h exp=1", stall_req); end
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        settle();
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fl_drop_req2 got=%0h exp=1", mem_req); end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL fl_drop_ack_stall got=%0h exp=0", stall_req); end
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_err++; $display("FAIL fl_discard got=%0h/%0h exp=0/0", inst_valid, mem_req);
        end
        n_cmp++; if (inst !== prev) begin n_err++; $display("FAIL fl_inst_hold got=%0h exp=%0h", inst, prev); end
        pc = 32'h180; ce = 1'b1;
        settle();
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL fl_new_stall got=%0h exp=1", stall_req); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h180) begin
            n_err++; $display("FAIL fl_new_addr got=%0h/%0h exp=1/180", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222; ce = 1'b0;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h1111_2222) begin
            n_err++; $display("FAIL fl_new_data got=%0h/%0h exp=1/11112222", inst_valid, inst);
        end
        tick();
    endtask

    task automatic test_misaligned();
        pc = 32'h203; ce = 1'b1;
        tick();
        n_cmp++; if (mem_addr !== 32'h200) begin n_err++; $display("FAIL mis_addr got=%0h exp=200", mem_addr); end
        ce = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0203;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0000_0203) begin
            n_err++; $display("FAIL mis_data got=%0h/%0h exp=1/203", inst_valid, inst);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        pc = 32'h400; ce = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hAAAA_0001; pc = 32'h404;
        tick();
        mem_ack = 1'b0;
        settle();
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'hAAAA_0001) begin
            n_err++; $display("FAIL b2b_first got=%0h/%0h exp=1/aaaa0001", inst_valid, inst);
        end
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL b2b_next_start got=%0h exp=1", stall_req); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h404) begin
            n_err++; $display("FAIL b2b_addr2 got=%0h/%0h exp=1/404", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 32'hBBBB_0002; pc = 32'h408; ce = 1'b0;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'hBBBB_0002) begin
            n_err++; $display("FAIL b2b_second got=%0h/%0h exp=1/bbbb0002", inst_valid, inst);
        end
        tick();
        n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL b2b_end got=%0h exp=0", inst_valid); end
        // Flush coinciding with the acknowledge discards the word.
        pc = 32'h500; ce = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'hCCCC_0003; flush = 1'b1; ce = 1'b0;
        settle();
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL ackfl_stall got=%0h exp=0", stall_req); end
        tick();
        mem_ack = 1'b0; flush = 1'b0;
        n_cmp++; if (inst_valid !== 1'b0 || mem_req !== 1'b0 || inst !== 32'hBBBB_0002) begin
            n_err++; $display("FAIL ackfl_discard got=%0h/%0h/%0h exp=0/0/bbbb0002", inst_valid, mem_req, inst);
        end
    endtask

    task automatic test_flush_idle();
        pc = 32'h600; ce = 1'b1; flush = 1'b1;
        settle();
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL fli_stall got=%0h exp=1", stall_req); end
        tick();
        flush = 1'b0; ce = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h600 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL fli_proceed got=%0h/%0h/%0h exp=1/600/0", mem_req, mem_addr, inst_valid);
        end
        mem_ack = 1'b1; mem_rdata = 32'h0600_0600;
        tick();
        mem_ack = 1'b0;
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0600_0600) begin
            n_err++; $display("FAIL fli_data got=%0h/%0h exp=1/6000600", inst_valid, inst);
        end
        tick();
    endtask

`ifdef IFETCH_HOLD_BUF_EN
    task automatic test_buffer();
        pc = 32'h40; ce = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0C00_0040;
        tick();
        mem_ack = 1'b0;
        settle();
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0C00_0040) begin
            n_err++; $display("FAIL buf_fill got=%0h/%0h exp=1/c000040", inst_valid, inst);
        end
        n_cmp++; if (stall_req !== 1'b0) begin n_err++; $display("FAIL buf_hit_stall got=%0h exp=0", stall_req); end
        tick();
        ce = 1'b0;
        n_cmp++; if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst !== 32'h0C00_0040) begin
            n_err++; $display("FAIL buf_hit got=%0h/%0h/%0h exp=0/1/c000040", mem_req, inst_valid, inst);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0; ce = 1'b1;
        settle();
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL buf_flush_stall got=%0h exp=1", stall_req); end
        tick();
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40) begin
            n_err++; $display("FAIL buf_flush_bus got=%0h/%0h exp=1/40", mem_req, mem_addr);
        end
        ce = 1'b0; mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask
`else
    task automatic test_no_buffer();
        pc = 32'h40; ce = 1'b1;
        tick();
        mem_ack = 1'b1; mem_rdata = 32'h0C00_0040;
        tick();
        mem_ack = 1'b0;
        settle();
        n_cmp++; if (inst_valid !== 1'b1 || inst !== 32'h0C00_0040) begin
            n_err++; $display("FAIL nobuf_fill got=%0h/%0h exp=1/c000040", inst_valid, inst);
        end
        n_cmp++; if (stall_req !== 1'b1) begin n_err++; $display("FAIL nobuf_stall got=%0h exp=1", stall_req); end
        tick();
        ce = 1'b0;
        n_cmp++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || inst_valid !== 1'b0) begin
            n_err++; $display("FAIL nobuf_bus got=%0h/%0h/%0h exp=1/40/0", mem_req, mem_addr, inst_valid);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_reset_mid_req();
        test_zero_wait();
        test_wait_states();
        test_flush_mid_fetch();
        test_misaligned();
        test_back_to_back();
        test_flush_idle();
`ifdef IFETCH_HOLD_BUF_EN
        test_buffer();
`else
        test_no_buffer();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
